// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Holds the program counter and fetches one instruction word at a time from
//   instruction memory. After an instruction commits, it picks the next PC
//   from the branch-resolve stage. If that PC is not word-aligned, the unit
//   raises a sticky fault and halts until reset.
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   pc_control      next-PC select: 00 pc+4, 01 branch, 10 jump, 11 pc+4
//   branch_target   taken-branch address
//   jump_target     JAL/JALR address
//   instr_done      one-cycle commit strobe for the instruction in instr
//   imem_req/addr   instruction memory read request / address
//   imem_ack/rdata  read response; ack marks rdata as valid
//   pc, pc_plus4    address of the held instruction, and that address + 4
//   instr           latched instruction word
//   instr_valid     instr/pc may be executed
//   misaligned      sticky fault flag
//   fault_addr      the misaligned next PC that caused the fault
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_control,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic        instr_done,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        misaligned,
    output logic [31:0] fault_addr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        mis_q, mis_d;
    logic [31:0] fault_q, fault_d;
    logic [31:0] next_pc;

    // The adder wraps modulo 2^32, so FFFF_FFFC + 4 gives 0. That result is
    // aligned and does not raise a fault.
    assign pc_plus4 = pc_q + 32'd4;

    // Reserved select 11 falls through to sequential flow.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_control)
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = jump_target;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            instr_q <= NOP;
            mis_q   <= 1'b0;
            fault_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                // The request is combinational from state, so an ack in the
                // first FETCH cycle is accepted.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (instr_done) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end else begin
                        fault_d = next_pc;
                        mis_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            default: state_d = HALT;
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign misaligned  = mis_q;
    assign fault_addr  = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_control = 2'b00;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] jump_target = 32'h0;
    logic        instr_done = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc, pc_plus4, instr, fault_addr;
    logic        instr_valid, misaligned;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .pc_control(pc_control),
        .branch_target(branch_target), .jump_target(jump_target),
        .instr_done(instr_done), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
        .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
        .misaligned(misaligned), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    // Reference model. It tracks what the unit is doing (booting, waiting on
    // memory, holding an instruction, or halted) plus the architectural
    // values implied by the rules.
    int          m_mode;  // 0 boot, 1 waiting on memory, 2 executing, 3 halted
    logic [31:0] m_pc, m_instr, m_fault;
    logic        m_mis;

    task automatic model_step();
        logic [31:0] np;
        if (rst) begin
            m_mode = 0; m_pc = RV; m_instr = NOP; m_mis = 1'b0; m_fault = 32'h0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (imem_ack) begin m_instr = imem_rdata; m_mode = 2; end
        end else if (m_mode == 2 && instr_done) begin
            np = (pc_control == 2'b01) ? branch_target :
                 (pc_control == 2'b10) ? jump_target : m_pc + 32'd4;
            if (np % 4 == 0) begin m_pc = np; m_mode = 1; end
            else begin m_fault = np; m_mis = 1'b1; m_mode = 3; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req",    {31'h0, imem_req},    {31'h0, m_mode == 1});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("pc",          pc,                   m_pc);
        chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
        chk("instr",       instr,                m_instr);
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_mode == 2});
        chk("misaligned",  {31'h0, misaligned},  {31'h0, m_mis});
        chk("fault_addr",  fault_addr,           m_fault);
    endtask

    // Inputs are set just after an edge. This task advances one edge, applies
    // the model, and compares 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Noise on inputs the unit must ignore in the current cycle.
    task automatic scramble();
        pc_control    = 2'($urandom);
        branch_target = $urandom;
        jump_target   = $urandom;
        imem_rdata    = $urandom;
    endtask

    task automatic do_fetch(input logic [31:0] word, input int wait_cyc);
        imem_ack = 1'b0;
        for (int i = 0; i < wait_cyc; i++) begin
            scramble();
            instr_done = 1'($urandom);
            tick();
        end
        instr_done = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic retire(input logic [1:0] ctl, input logic [31:0] bt,
                          input logic [31:0] jt, input int idle);
        for (int i = 0; i < idle; i++) begin
            scramble();
            imem_ack   = 1'($urandom);
            instr_done = 1'b0;
            tick();
        end
        imem_ack = 1'b0;
        pc_control = ctl; branch_target = bt; jump_target = jt;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        scramble();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset: two cycles, then check the reset values.
        rst = 1'b1;
        @(posedge clk); model_step();
        tick();
        chk("reset_instr_nop", instr, NOP);
        rst = 1'b0;
        tick();

        // First fetch: ack arrives 2 cycles after req rises. The address is
        // held for all 3 request cycles.
        do_fetch(32'h0050_0093, 2);
        chk("first_instr", instr, 32'h0050_0093);
        chk("first_valid", {31'h0, instr_valid}, 32'h1);

        // Move to pc=0x10, then retire sequentially to 0x14.
        retire(2'b10, 32'h0, 32'h10, 1);
        do_fetch($urandom, 0);
        retire(2'b00, $urandom, $urandom, 2);
        chk("seq_addr", imem_addr, 32'h14);
        chk("seq_plus4", pc_plus4, 32'h18);
        do_fetch($urandom, 1);

        // From pc=0x10: branch to 0x40, then jump to 0x8.
        retire(2'b10, 32'h0, 32'h10, 0);
        do_fetch($urandom, 0);
        retire(2'b01, 32'h40, $urandom, 1);
        chk("branch_addr", imem_addr, 32'h40);
        do_fetch($urandom, 3);
        retire(2'b10, $urandom, 32'h8, 0);
        chk("jump_addr", imem_addr, 32'h8);
        do_fetch($urandom, 0);
        retire(2'b11, $urandom, $urandom, 0);   // reserved select means pc+4
        chk("reserved_addr", imem_addr, 32'hC);
        do_fetch($urandom, 0);

        // Sequential wrap from FFFF_FFFC to 0 with no fault.
        retire(2'b10, 32'h0, 32'hFFFF_FFFC, 0);
        do_fetch($urandom, 1);
        retire(2'b00, $urandom, $urandom, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_nofault", {31'h0, misaligned}, 32'h0);
        do_fetch($urandom, 0);

        // Misaligned jump: the fault sticks, ack is ignored, and reset restarts.
        retire(2'b10, $urandom, 32'h22, 0);
        chk("mis_flag", {31'h0, misaligned}, 32'h1);
        chk("mis_fault_addr", fault_addr, 32'h22);
        chk("mis_pc_held", pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = $urandom; instr_done = 1'b1;
            tick();
        end
        imem_ack = 1'b0; instr_done = 1'b0;
        do_reset();
        chk("restart_addr", imem_addr, RV);

        // Reset during FETCH while an ack arrives: the ack is dropped.
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rst = 1'b1;
        tick();
        chk("rst_ack_instr", instr, NOP);
        chk("rst_ack_valid", {31'h0, instr_valid}, 32'h0);
        imem_ack = 1'b0; rst = 1'b0;
        tick();

        // Randomized traffic. Targets are occasionally misaligned.
        for (int n = 0; n < 80; n++) begin
            if (m_mode == 3) begin
                imem_ack = 1'($urandom); instr_done = 1'($urandom);
                tick();
                imem_ack = 1'b0; instr_done = 1'b0;
                do_reset();
            end else if (m_mode == 1) begin
                do_fetch($urandom, $urandom_range(0, 3));
            end else if (m_mode == 2) begin
                logic [31:0] bt, jt;
                bt = $urandom & 32'hFFFF_FFFC;
                jt = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 5) == 0) bt[1:0] = 2'($urandom);
                if ($urandom_range(0, 5) == 0) jt[1:0] = 2'($urandom);
                retire(2'($urandom), bt, jt, $urandom_range(0, 2));
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
